pbus_arbiter: RTL and testbench
===============================

Name: pbus_arbiter

Overview:
- Owns the synth engine's 8-bit parameter bus (adr/data/write/read/bank selects) that the mixer and sibling engine blocks latch patch data from.
- Shares the bus between three requesters: MIDI controller writes, sysex patch-load writes and sysex patch-dump reads.
- Runs each access as a fixed-timing bus cycle and returns an ack, plus read data for dumps.
- Sits between the MIDI/sysex decoder and the synth engine parameter registers.

Parameters:
- STROBE_CYC, 2, cycles the write (low) or read (high) strobe is held; legal range 1..15.
- AGE_MAX, 16, max cycles a pending dump read may lose arbitration (used only with PBUS_AGE_EN).
- N_REQ, 3, requester count, fixed: 0 = midi, 1 = load, 2 = dump.

Ports:
- sCLK_XVXENVS  in  1  engine clock; all state changes on posedge.
- iRST_N  in  1  asynchronous, active-low reset.
- req  in  3  per-requester request, held until ack.
- req_bank  in  3x2  per-requester bank: 0 = osc, 1 = com, 2 = m1, 3 = m2.
- req_adr  in  3x7  per-requester address.
- req_wdata  in  2x8  write data for requesters 0 and 1.
- ack  out  3  one-cycle acknowledge, one bit per requester.
- dump_rdata  out  8  read data, valid in the cycle dump ack is high.
- adr  out  7  bus address.
- wdata  out  8  bus write data.
- data_oe  out  1  high while the arbiter drives the shared data bus.
- rdata  in  8  shared data bus value, sampled during reads.
- write  out  1  active-low write strobe.
- read  out  1  active-high read strobe.
- osc_sel, com_sel, m1_sel, m2_sel  out  1 each  one-hot bank selects.
- sysex_data_patch_send  out  1  high for the whole of a dump cycle.

Behaviour:
- Reset values: write = 1; read = 0; all sels = 0; data_oe = 0; adr = 0; wdata = 0; ack = 0; dump_rdata = 0; sysex_data_patch_send = 0; FSM = IDLE; age counter = 0.
- IDLE:
  - If any req is set, pick the owner by fixed priority midi > load > dump, then latch the owner's bank, adr and wdata into cycle registers. Go to SETUP.
  - With no req, stay in IDLE.
- SETUP (1 cycle):
  - Drive adr and the one-hot sel from the latched bank.
  - Write cycle: drive wdata and set data_oe = 1.
  - Dump cycle: set sysex_data_patch_send = 1.
  - Strobes stay inactive.
- STROBE (STROBE_CYC cycles, 4-bit counter):
  - Write cycle: write = 0.
  - Read cycle: read = 1.
  - adr, sel and wdata are held stable.
- HOLD (1 cycle):
  - Strobe returns inactive; adr, sel and data are still held.
  - Read cycle: capture rdata into dump_rdata at the end of HOLD.
- ACK (1 cycle):
  - ack[owner] = 1 if req[owner] is still high; otherwise the ack is suppressed but the cycle still completes.
  - sels, data_oe and sysex_data_patch_send clear. Go to IDLE.
- Latency: req seen in IDLE → ack = STROBE_CYC + 3 cycles after the grant edge. Minimum spacing between bus cycles is STROBE_CYC + 4.
- Latched fields are immune to requester input changes after the grant.
- A requester re-asserting in the cycle after its ack is arbitrated normally in IDLE. There is no back-to-back grant without an IDLE cycle.
- Simultaneous req from all three requesters: midi is granted; load is granted next, then dump.
- Reset asserted mid-cycle: every output returns to its reset value immediately and asynchronously. The aborted access is not acked, and requesters must re-request.
- Exactly one sel is ever high, and only in SETUP/STROBE/HOLD. write = 0 and read = 1 never occur together.

Optional Feature:
- Macro: PBUS_AGE_EN.
- Defined:
  - An age counter increments each IDLE grant decision where dump is pending but not granted.
  - When the counter reaches AGE_MAX, dump wins the next arbitration regardless of priority.
  - The counter clears on a dump grant and saturates at AGE_MAX.
- Undefined: pure fixed priority; a dump can starve under continuous midi/load traffic. No age counter is synthesized.

Decomposition:
- Shared package synth_bus_pkg holds:
  - bank enum: BANK_OSC = 0, BANK_COM = 1, BANK_M1 = 2, BANK_M2 = 3;
  - requester index constants: REQ_MIDI, REQ_LOAD, REQ_DUMP;
  - FSM state typedef: IDLE, SETUP, STROBE, HOLD, ACK;
  - widths: ADR_W = 7, DATA_W = 8.
- One sub-module, pbus_prio_sel: combinational priority plus the optional aging logic, outputting the owner index and a grant-valid bit.

Test Plan:
- Midi req only, bank 0, adr 0x12, wdata 0x55, STROBE_CYC = 2 → osc_sel = 1, adr = 0x12, wdata = 0x55, write low for exactly 2 cycles, ack[0] 5 cycles after grant.
- Dump req, bank 2, adr 0x23, bench drives rdata = 0xA7 during read → read high for 2 cycles, sysex_data_patch_send high for SETUP through HOLD, dump_rdata = 0xA7 with ack[2].
- All three reqs asserted together and held → grant order midi, load, dump; acks spaced 6 cycles apart; never two sels high.
- Reset pulsed mid-STROBE of a load write → write returns to 1 and sels to 0 asynchronously, no ack[1]; after release, re-req completes normally.
- Midi req dropped during STROBE → cycle runs to ACK, ack[0] stays 0, FSM back in IDLE.
- With PBUS_AGE_EN, AGE_MAX = 4, continuous midi traffic plus a pending dump → dump granted at the 5th decision. Without the macro, dump is never granted while midi is held.

Source files
------------

// File: rtl/synth_bus_pkg.sv
// Shared types and constants for the synth engine parameter bus.
package synth_bus_pkg;

  localparam int ADR_W  = 7;
  localparam int DATA_W = 8;
  localparam int N_REQ  = 3;

  localparam logic [1:0] REQ_MIDI = 2'd0;
  localparam logic [1:0] REQ_LOAD = 2'd1;
  localparam logic [1:0] REQ_DUMP = 2'd2;

  typedef enum logic [1:0] {
    BANK_OSC = 2'd0,
    BANK_COM = 2'd1,
    BANK_M1  = 2'd2,
    BANK_M2  = 2'd3
  } bank_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    ACK    = 3'd4
  } state_e;

endpackage

// File: rtl/pbus_prio_sel.sv
// Requester priority select: midi > load > dump, with an aging override
// that lets a starved dump win outright.
module pbus_prio_sel
  import synth_bus_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic             age_force,
  output logic [1:0]       owner,
  output logic             grant_vld
);

  always_comb begin
    owner     = REQ_MIDI;
    grant_vld = |req;
    if (age_force && req[REQ_DUMP]) begin
      owner = REQ_DUMP;
    end else if (req[REQ_MIDI]) begin
      owner = REQ_MIDI;
    end else if (req[REQ_LOAD]) begin
      owner = REQ_LOAD;
    end else if (req[REQ_DUMP]) begin
      owner = REQ_DUMP;
    end
  end

endmodule

// File: rtl/pbus_arbiter.sv
// Parameter bus arbiter: grants one requester and runs a fixed-timing
// SETUP/STROBE/HOLD/ACK bus cycle. Define PBUS_AGE_EN to enable dump aging.
module pbus_arbiter
  import synth_bus_pkg::*;
#(
  parameter int STROBE_CYC = 2,
  parameter int AGE_MAX    = 16
) (
  input  logic                         sCLK_XVXENVS,
  input  logic                         iRST_N,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ-1:0][1:0]        req_bank,
  input  logic [N_REQ-1:0][ADR_W-1:0]  req_adr,
  input  logic [1:0][DATA_W-1:0]       req_wdata,
  output logic [N_REQ-1:0]             ack,
  output logic [DATA_W-1:0]            dump_rdata,
  output logic [ADR_W-1:0]             adr,
  output logic [DATA_W-1:0]            wdata,
  output logic                         data_oe,
  input  logic [DATA_W-1:0]            rdata,
  output logic                         write,
  output logic                         read,
  output logic                         osc_sel,
  output logic                         com_sel,
  output logic                         m1_sel,
  output logic                         m2_sel,
  output logic                         sysex_data_patch_send
);

  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYC - 1);

  state_e                 state_q, state_d;
  logic [1:0]             owner_q, owner_d;
  bank_e                  bank_q, bank_d;
  logic [ADR_W-1:0]       adr_q, adr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [N_REQ-1:0]       ack_q, ack_d;
  logic [DATA_W-1:0]      dump_rdata_q, dump_rdata_d;

  logic [1:0]             owner;
  logic                   grant_vld;
  logic                   age_force;

  pbus_prio_sel u_prio_sel (
    .req       (req),
    .age_force (age_force),
    .owner     (owner),
    .grant_vld (grant_vld)
  );

`ifdef PBUS_AGE_EN
  localparam int AGE_W = $clog2(AGE_MAX + 1);
  logic [AGE_W-1:0] age_q, age_d;

  // Counts lost arbitration decisions of a pending dump; saturates at AGE_MAX.
  always_comb begin
    age_d = age_q;
    if (state_q == IDLE && grant_vld) begin
      if (owner == REQ_DUMP) begin
        age_d = '0;
      end else if (req[REQ_DUMP] && age_q != AGE_W'(AGE_MAX)) begin
        age_d = age_q + 1'b1;
      end
    end
  end

  always_ff @(posedge sCLK_XVXENVS or negedge iRST_N) begin
    if (!iRST_N) age_q <= '0;
    else         age_q <= age_d;
  end

  assign age_force = (age_q == AGE_W'(AGE_MAX));
`else
  // Aging compiled out: the override can never fire.
  assign age_force = (AGE_MAX < 0);
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    bank_d       = bank_q;
    adr_d        = adr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    ack_d        = '0;
    dump_rdata_d = dump_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          owner_d = owner;
          bank_d  = bank_e'(req_bank[owner]);
          adr_d   = req_adr[owner];
          if (owner != REQ_DUMP) wdata_d = req_wdata[owner[0]];
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = STROBE_LAST;
        state_d = STROBE;
      end
      STROBE: begin
        if (cnt_q == 4'd0) state_d = HOLD;
        else               cnt_d   = cnt_q - 4'd1;
      end
      HOLD: begin
        if (owner_q == REQ_DUMP) dump_rdata_d = rdata;
        state_d = ACK;
      end
      ACK: begin
        // A requester that withdrew mid-cycle gets no ack.
        ack_d[owner_q] = req[owner_q];
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sCLK_XVXENVS or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q      <= IDLE;
      owner_q      <= REQ_MIDI;
      bank_q       <= BANK_OSC;
      adr_q        <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      ack_q        <= '0;
      dump_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      bank_q       <= bank_d;
      adr_q        <= adr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      ack_q        <= ack_d;
      dump_rdata_q <= dump_rdata_d;
    end
  end

  logic bus_active;
  logic is_dump;

  assign bus_active = (state_q == SETUP) || (state_q == STROBE) || (state_q == HOLD);
  assign is_dump    = (owner_q == REQ_DUMP);

  assign adr                   = adr_q;
  assign wdata                 = wdata_q;
  assign ack                   = ack_q;
  assign dump_rdata            = dump_rdata_q;
  assign data_oe               = bus_active && !is_dump;
  assign sysex_data_patch_send = bus_active && is_dump;
  assign write                 = !((state_q == STROBE) && !is_dump);
  assign read                  = (state_q == STROBE) && is_dump;
  assign osc_sel               = bus_active && (bank_q == BANK_OSC);
  assign com_sel               = bus_active && (bank_q == BANK_COM);
  assign m1_sel                = bus_active && (bank_q == BANK_M1);
  assign m2_sel                = bus_active && (bank_q == BANK_M2);

endmodule

// File: tb/tb_pbus_arbiter.sv
// Directed bench for pbus_arbiter: a cycle-by-cycle vector table plus
// hand-written sequences for priority, reset abort, dropped request and aging.
module tb_pbus_arbiter;
  import synth_bus_pkg::*;

  logic                         clk;
  logic                         rst_n;
  logic [N_REQ-1:0]             req;
  logic [N_REQ-1:0][1:0]        req_bank;
  logic [N_REQ-1:0][ADR_W-1:0]  req_adr;
  logic [1:0][DATA_W-1:0]       req_wdata;
  logic [N_REQ-1:0]             ack;
  logic [DATA_W-1:0]            dump_rdata;
  logic [ADR_W-1:0]             adr;
  logic [DATA_W-1:0]            wdata;
  logic                         data_oe;
  logic [DATA_W-1:0]            rdata;
  logic                         write;
  logic                         read;
  logic                         osc_sel, com_sel, m1_sel, m2_sel;
  logic                         sysex_data_patch_send;

  int vec_count  = 0;
  int miss_count = 0;

  pbus_arbiter #(.STROBE_CYC(2), .AGE_MAX(4)) dut (
    .sCLK_XVXENVS          (clk),
    .iRST_N                (rst_n),
    .req                   (req),
    .req_bank              (req_bank),
    .req_adr               (req_adr),
    .req_wdata             (req_wdata),
    .ack                   (ack),
    .dump_rdata            (dump_rdata),
    .adr                   (adr),
    .wdata                 (wdata),
    .data_oe               (data_oe),
    .rdata                 (rdata),
    .write                 (write),
    .read                  (read),
    .osc_sel               (osc_sel),
    .com_sel               (com_sel),
    .m1_sel                (m1_sel),
    .m2_sel                (m2_sel),
    .sysex_data_patch_send (sysex_data_patch_send)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    logic [2:0] req;
    logic [7:0] rdata;
    logic [2:0] ack;
    logic       wr_n;
    logic       rd;
    logic [3:0] sel;
    logic       oe;
    logic       send;
    logic [6:0] adr;
    logic [7:0] wdata;
    logic [7:0] drd;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic [2:0] r, input logic [7:0] rd_in,
                              input logic [2:0] a, input logic wn, input logic rdv,
                              input logic [3:0] s, input logic o, input logic snd,
                              input logic [6:0] ad, input logic [7:0] wd,
                              input logic [7:0] dr);
    vec_t v;
    v.req = r; v.rdata = rd_in; v.ack = a; v.wr_n = wn; v.rd = rdv;
    v.sel = s; v.oe = o; v.send = snd; v.adr = ad; v.wdata = wd; v.drd = dr;
    return v;
  endfunction

  function automatic logic [63:0] pack_exp(input vec_t v);
    return 64'({v.ack, v.wr_n, v.rd, v.sel, v.oe, v.send, v.adr, v.wdata, v.drd});
  endfunction

  function automatic logic [63:0] pack_out();
    return 64'({ack, write, read, m2_sel, m1_sel, com_sel, osc_sel,
                data_oe, sysex_data_patch_send, adr, wdata, dump_rdata});
  endfunction

  function automatic logic [3:0] sels();
    return {m2_sel, m1_sel, com_sel, osc_sel};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    req   = v.req;
    rdata = v.rdata;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  logic [2:0] ack_order [3];
  int         ack_time  [3];
  int         n_acks;
  int         viol;
  int         idx;
  logic [2:0] ack_seen;
  int         decisions;
  int         dump_dec;
  logic       prev_active;
  vec_t       reset_vec;

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    rdata     = '0;
    req_bank[0] = 2'd0; req_adr[0] = 7'h12; req_wdata[0] = 8'h55;
    req_bank[1] = 2'd1; req_adr[1] = 7'h34; req_wdata[1] = 8'h66;
    req_bank[2] = 2'd2; req_adr[2] = 7'h23;

    //          req   rdata  ack  wr rd sel    oe snd adr    wdata  drd
    vecs[0]  = mk(3'b001, 8'h00, 3'b000, 1, 0, 4'b0001, 1, 0, 7'h12, 8'h55, 8'h00);
    vecs[1]  = mk(3'b001, 8'h00, 3'b000, 0, 0, 4'b0001, 1, 0, 7'h12, 8'h55, 8'h00);
    vecs[2]  = mk(3'b001, 8'h00, 3'b000, 0, 0, 4'b0001, 1, 0, 7'h12, 8'h55, 8'h00);
    vecs[3]  = mk(3'b001, 8'h00, 3'b000, 1, 0, 4'b0001, 1, 0, 7'h12, 8'h55, 8'h00);
    vecs[4]  = mk(3'b001, 8'h00, 3'b000, 1, 0, 4'b0000, 0, 0, 7'h12, 8'h55, 8'h00);
    vecs[5]  = mk(3'b001, 8'h00, 3'b001, 1, 0, 4'b0000, 0, 0, 7'h12, 8'h55, 8'h00);
    vecs[6]  = mk(3'b000, 8'h00, 3'b000, 1, 0, 4'b0000, 0, 0, 7'h12, 8'h55, 8'h00);
    vecs[7]  = mk(3'b100, 8'h00, 3'b000, 1, 0, 4'b0100, 0, 1, 7'h23, 8'h55, 8'h00);
    vecs[8]  = mk(3'b100, 8'hA7, 3'b000, 1, 1, 4'b0100, 0, 1, 7'h23, 8'h55, 8'h00);
    vecs[9]  = mk(3'b100, 8'hA7, 3'b000, 1, 1, 4'b0100, 0, 1, 7'h23, 8'h55, 8'h00);
    vecs[10] = mk(3'b100, 8'hA7, 3'b000, 1, 0, 4'b0100, 0, 1, 7'h23, 8'h55, 8'h00);
    vecs[11] = mk(3'b100, 8'hA7, 3'b000, 1, 0, 4'b0000, 0, 0, 7'h23, 8'h55, 8'hA7);
    vecs[12] = mk(3'b100, 8'h00, 3'b100, 1, 0, 4'b0000, 0, 0, 7'h23, 8'h55, 8'hA7);
    vecs[13] = mk(3'b000, 8'h00, 3'b000, 1, 0, 4'b0000, 0, 0, 7'h23, 8'h55, 8'hA7);

    reset_vec = mk(3'b000, 8'h00, 3'b000, 1, 0, 4'b0000, 0, 0, 7'h00, 8'h00, 8'h00);

    repeat (3) tick();
    checkOutput("reset_state", pack_out(), pack_exp(reset_vec));
    rst_n = 1'b1;
    tick();
    checkOutput("idle_after_release", pack_out(), pack_exp(reset_vec));

    // Single midi write followed by a single dump read, cycle by cycle.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("vec%0d", i), pack_out(), pack_exp(vecs[i]));
    end

    // All three requesters at once; each drops its request on seeing its ack.
    rdata  = 8'h3C;
    req    = 3'b111;
    n_acks = 0;
    viol   = 0;
    for (int i = 0; i < 3; i++) begin ack_order[i] = '0; ack_time[i] = 0; end
    for (int c = 1; c <= 40 && n_acks < 3; c++) begin
      tick();
      if ($countones(sels()) > 1 || (!write && read)) viol++;
      if (ack != 3'b000) begin
        ack_order[n_acks] = ack;
        ack_time[n_acks]  = c;
        if (ack[2]) checkOutput("all3_dump_rdata", 64'(dump_rdata), 64'h3C);
        req = req & ~ack;
        n_acks++;
      end
    end
    checkOutput("all3_first_midi",  64'(ack_order[0]), 64'b001);
    checkOutput("all3_second_load", 64'(ack_order[1]), 64'b010);
    checkOutput("all3_third_dump",  64'(ack_order[2]), 64'b100);
    checkOutput("all3_spacing_01",  64'(ack_time[1] - ack_time[0]), 64'd6);
    checkOutput("all3_spacing_12",  64'(ack_time[2] - ack_time[1]), 64'd6);
    checkOutput("all3_sel_strobe_violations", 64'(viol), 64'd0);
    req = '0;
    tick();

    // Reset asserted in the middle of a load write strobe.
    req = 3'b010;
    tick();
    tick();
    checkOutput("load_strobe_low", 64'(write), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_outputs", pack_out(), pack_exp(reset_vec));
    #1;
    rst_n = 1'b1;
    tick();
    checkOutput("rereq_setup", 64'({sels(), adr, wdata, data_oe}),
                64'({4'b0010, 7'h34, 8'h66, 1'b1}));
    idx = 0;
    for (int c = 1; c <= 10 && idx == 0; c++) begin
      tick();
      if (ack != 3'b000) begin
        idx = c;
        checkOutput("rereq_ack_bits", 64'(ack), 64'b010);
        req = '0;
      end
    end
    checkOutput("rereq_ack_latency", 64'(idx), 64'd5);
    req = '0;
    tick();

    // Midi withdraws during STROBE while its inputs change under the latch.
    req = 3'b001;
    tick();
    tick();
    req = 3'b000;
    req_adr[0]   = 7'h7F;
    req_wdata[0] = 8'hAA;
    tick();
    checkOutput("latched_fields", 64'({adr, wdata, write}), 64'({7'h12, 8'h55, 1'b0}));
    ack_seen = '0;
    repeat (6) begin
      tick();
      ack_seen = ack_seen | ack;
    end
    checkOutput("dropped_no_ack", 64'(ack_seen), 64'd0);
    checkOutput("dropped_idle_outputs",
                64'({write, read, sels(), data_oe, sysex_data_patch_send}),
                64'({1'b1, 1'b0, 4'b0000, 1'b0, 1'b0}));
    req_adr[0]   = 7'h12;
    req_wdata[0] = 8'h55;
    req = 3'b010;
    tick();
    checkOutput("back_in_idle_grant", 64'({sels(), adr}), 64'({4'b0010, 7'h34}));
    for (int c = 1; c <= 10 && req != 3'b000; c++) begin
      tick();
      if (ack[1]) req = '0;
    end
    tick();

    // Continuous midi traffic with a pending dump.
    rdata       = 8'h5A;
    req         = 3'b101;
    decisions   = 0;
    dump_dec    = 0;
    prev_active = 1'b0;
    for (int c = 0; c < 64; c++) begin
      tick();
      if ((sels() != 4'b0000) && !prev_active) begin
        decisions++;
        if (sysex_data_patch_send && dump_dec == 0) dump_dec = decisions;
      end
      prev_active = (sels() != 4'b0000);
      if (ack[2]) req[2] = 1'b0;
    end
`ifdef PBUS_AGE_EN
    checkOutput("aging_dump_decision", 64'(dump_dec), 64'd5);
`else
    checkOutput("starved_dump_never_granted", 64'(dump_dec), 64'd0);
`endif
    checkOutput("midi_traffic_decisions", 64'(decisions >= 10), 64'd1);
    req = '0;
    repeat (8) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
